// File: rtl/llsc_monitor_if.sv
`default_nettype none
// ============================================================================
// Module      : llsc_monitor_if
// Description : Bundle of MEM-stage LL/SC requests, exception flush, store
//               snoops and the reservation status returned by llsc_monitor.
//               slave  modport : the monitor (consumes requests, drives status)
//               master modport : the MEM stage / interconnect side
//               Ports carried:
//                 flush, ll_valid, ll_addr, sc_valid, sc_addr,
//                 snoop_valid, snoop_addr          (to monitor)
//                 sc_success, llbit_o, lladdr_o,
//                 resv_lost                        (from monitor)
// Revision    : 1.0 - initial release
// ============================================================================
interface llsc_monitor_if #(
  parameter int ADDR_W = 32
);
  logic              flush;
  logic              ll_valid;
  logic [ADDR_W-1:0] ll_addr;
  logic              sc_valid;
  logic [ADDR_W-1:0] sc_addr;
  logic              snoop_valid;
  logic [ADDR_W-1:0] snoop_addr;
  logic              sc_success;
  logic              llbit_o;
  logic [ADDR_W-1:0] lladdr_o;
  logic              resv_lost;

  modport slave (
    input  flush, ll_valid, ll_addr, sc_valid, sc_addr, snoop_valid, snoop_addr,
    output sc_success, llbit_o, lladdr_o, resv_lost
  );

  modport master (
    output flush, ll_valid, ll_addr, sc_valid, sc_addr, snoop_valid, snoop_addr,
    input  sc_success, llbit_o, lladdr_o, resv_lost
  );
endinterface
`default_nettype wire

// File: rtl/llsc_monitor.sv
`default_nettype none
// ============================================================================
// Module      : llsc_monitor
// Description : LL/SC reservation controller. Holds the link bit and link
//               address, kills the reservation on a matching remote store
//               snoop or after TIMEOUT cycles, and returns a zero-latency SC
//               pass/fail result to the MEM stage.
//               Ports:
//                 clk  - clock, rising edge
//                 rst  - synchronous active-high reset
//                 bus  - llsc_monitor_if.slave (requests in, status out)
//               ADDR_W must match the ADDR_W of the connected interface.
// Revision    : 1.0 - initial release
// ============================================================================
module llsc_monitor #(
  parameter int ADDR_W   = 32,
  parameter int GRAN_LSB = 2,
  parameter int TIMEOUT  = 1024,
  parameter int CNT_W    = 11
) (
  input  wire logic        clk,
  input  wire logic        rst,
  llsc_monitor_if.slave    bus
);

  typedef enum logic [0:0] {
    ST_IDLE     = 1'b0,
    ST_RESERVED = 1'b1
  } state_t;

  localparam bit             c_TIMEOUT_EN   = (TIMEOUT != 0);
  // Terminal count of a live reservation; unused when the timeout is off.
  localparam logic [CNT_W-1:0] c_TIMEOUT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam logic [CNT_W-1:0] c_CNT_ONE      = CNT_W'(1);

  state_t            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [ADDR_W-1:0] r_lladdr, w_lladdr_nxt;
  logic              r_lost, w_lost_nxt;
  logic              w_llbit;
  logic              w_snoop_hit;
  logic              w_ll_snoop_clash;

  // Addresses are equal when they fall into the same granule.
  function automatic logic f_match(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b);
    return a[ADDR_W-1:GRAN_LSB] == b[ADDR_W-1:GRAN_LSB];
  endfunction

  assign w_llbit          = (r_state == ST_RESERVED);
  assign w_snoop_hit      = bus.snoop_valid & w_llbit & f_match(bus.snoop_addr, r_lladdr);
  // A remote store to the granule being linked in this very cycle may have
  // raced the load, so the reservation is never established.
  assign w_ll_snoop_clash = bus.snoop_valid & f_match(bus.snoop_addr, bus.ll_addr);

  assign bus.sc_success = bus.sc_valid & w_llbit & f_match(bus.sc_addr, r_lladdr)
                          & ~w_snoop_hit & ~bus.flush;
  assign bus.llbit_o    = w_llbit;
  assign bus.lladdr_o   = r_lladdr;
  assign bus.resv_lost  = r_lost;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_lladdr <= '0;
      r_lost   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_lladdr <= w_lladdr_nxt;
      r_lost   <= w_lost_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_lladdr_nxt = r_lladdr;
    w_lost_nxt   = 1'b0;

    if (bus.flush) begin
      // Architectural clear, not reported as a loss.
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = '0;
    end else if (bus.sc_valid) begin
      // SC consumes the reservation whether it passed or failed; a
      // simultaneous LL is an illegal combination and is dropped.
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = '0;
    end else if (bus.ll_valid) begin
      w_lladdr_nxt = bus.ll_addr;
      w_cnt_nxt    = '0;
      w_state_nxt  = w_ll_snoop_clash ? ST_IDLE : ST_RESERVED;
    end else if (w_snoop_hit) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = '0;
      w_lost_nxt  = 1'b1;
    end else if (w_llbit && c_TIMEOUT_EN && (r_cnt == c_TIMEOUT_LAST)) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = '0;
      w_lost_nxt  = 1'b1;
    end else if (w_llbit) begin
      // Saturate rather than wrap (only reachable with the timeout off).
      if (r_cnt != '1) begin
        w_cnt_nxt = r_cnt + c_CNT_ONE;
      end
    end else begin
      w_cnt_nxt = '0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_llsc_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_llsc_monitor
// Description : Directed self-checking bench for llsc_monitor (TIMEOUT=4,
//               word granule). Each cycle's expected outputs are queued when
//               the stimulus is applied and compared at the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_llsc_monitor;

  localparam int ADDR_W = 32;
  localparam int SEL_SC = 0, SEL_LLBIT = 1, SEL_LLADDR = 2, SEL_LOST = 3;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] val;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   n_assert = 0;
  int   n_fail   = 0;
  exp_t sb[$];

  llsc_monitor_if #(.ADDR_W(ADDR_W)) bus ();

  llsc_monitor #(
    .ADDR_W  (ADDR_W),
    .GRAN_LSB(2),
    .TIMEOUT (4),
    .CNT_W   (3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic clr();
    bus.flush       = 1'b0;
    bus.ll_valid    = 1'b0;
    bus.ll_addr     = '0;
    bus.sc_valid    = 1'b0;
    bus.sc_addr     = '0;
    bus.snoop_valid = 1'b0;
    bus.snoop_addr  = '0;
  endtask

  task automatic ex(input string tag, input int sel, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t        e;
    logic [31:0] act;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.sel)
        SEL_SC:     act = {31'd0, bus.sc_success};
        SEL_LLBIT:  act = {31'd0, bus.llbit_o};
        SEL_LLADDR: act = bus.lladdr_o;
        default:    act = {31'd0, bus.resv_lost};
      endcase
      n_assert++;
      assert (act === e.val) else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", e.tag, act, e.val);
      end
    end
  endtask

  // Compare this cycle's queued expectations, then advance past the edge.
  task automatic tick();
    @(negedge clk);
    drain();
    @(posedge clk);
    #1;
  endtask

  task automatic do_ll(input logic [31:0] a);
    clr(); bus.ll_valid = 1'b1; bus.ll_addr = a;
  endtask

  task automatic do_sc(input logic [31:0] a);
    clr(); bus.sc_valid = 1'b1; bus.sc_addr = a;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clr();
    rst = 1'b1;
    @(posedge clk); #1;
    ex("reset_llbit", SEL_LLBIT, 0); ex("reset_lladdr", SEL_LLADDR, 0);
    ex("reset_lost", SEL_LOST, 0);   ex("reset_sc", SEL_SC, 0);
    tick();
    rst = 1'b0;

    // 1: LL then SC two cycles later
    do_ll(32'h1000); ex("t1_pre_llbit", SEL_LLBIT, 0); tick();
    clr(); ex("t1_llbit", SEL_LLBIT, 1); ex("t1_lladdr", SEL_LLADDR, 32'h1000); tick();
    do_sc(32'h1000); ex("t1_sc_pass", SEL_SC, 1); tick();
    clr(); ex("t1_llbit_after", SEL_LLBIT, 0); ex("t1_lost", SEL_LOST, 0); tick();
    clr(); ex("t1_lost2", SEL_LOST, 0); tick();

    // 2: snoop to the same word kills the reservation
    do_ll(32'h1000); tick();
    clr(); bus.snoop_valid = 1'b1; bus.snoop_addr = 32'h1002;
    ex("t2_llbit_before", SEL_LLBIT, 1); tick();
    clr(); ex("t2_llbit", SEL_LLBIT, 0); ex("t2_lost", SEL_LOST, 1); tick();
    do_sc(32'h1000); ex("t2_sc_fail", SEL_SC, 0); ex("t2_lost_once", SEL_LOST, 0); tick();

    // 3: SC to another word fails and consumes the reservation
    do_ll(32'h1000); tick();
    do_sc(32'h1004); ex("t3_sc_wrong", SEL_SC, 0); ex("t3_llbit", SEL_LLBIT, 1); tick();
    do_sc(32'h1000); ex("t3_sc_consumed", SEL_SC, 0); ex("t3_llbit_gone", SEL_LLBIT, 0); tick();

    // 4a: SC with matching snoop in the same cycle
    do_ll(32'h3000); tick();
    do_sc(32'h3000); bus.snoop_valid = 1'b1; bus.snoop_addr = 32'h3000;
    ex("t4_sc_snoop", SEL_SC, 0); tick();
    clr(); ex("t4_llbit", SEL_LLBIT, 0); ex("t4_lost", SEL_LOST, 0); tick();
    // 4b: SC with flush
    do_ll(32'h3000); tick();
    do_sc(32'h3000); bus.flush = 1'b1; ex("t4_sc_flush", SEL_SC, 0); tick();
    clr(); ex("t4f_llbit", SEL_LLBIT, 0); ex("t4f_lost", SEL_LOST, 0); tick();
    // 4c: flush alone clears without a loss pulse
    do_ll(32'h3000); tick();
    clr(); bus.flush = 1'b1; ex("t4c_llbit", SEL_LLBIT, 1); tick();
    clr(); ex("t4c_llbit_after", SEL_LLBIT, 0); ex("t4c_lost", SEL_LOST, 0); tick();

    // Missing snoop has no effect; SC within the same word passes
    do_ll(32'h4000); tick();
    clr(); bus.snoop_valid = 1'b1; bus.snoop_addr = 32'h4004; tick();
    do_sc(32'h4003); ex("miss_sc_pass", SEL_SC, 1); ex("miss_lost", SEL_LOST, 0); tick();
    // Snoop in IDLE does nothing
    clr(); bus.snoop_valid = 1'b1; bus.snoop_addr = 32'h4000; tick();
    clr(); ex("idle_snoop_lost", SEL_LOST, 0); ex("idle_snoop_llbit", SEL_LLBIT, 0); tick();

    // LL racing a matching snoop is not established, address still captured
    do_ll(32'h5000); bus.snoop_valid = 1'b1; bus.snoop_addr = 32'h5001; tick();
    clr(); ex("clash_llbit", SEL_LLBIT, 0); ex("clash_lladdr", SEL_LLADDR, 32'h5000);
    ex("clash_lost", SEL_LOST, 0); tick();

    // SC and LL together: SC wins, LL ignored
    do_ll(32'h7000); tick();
    do_sc(32'h7000); bus.ll_valid = 1'b1; bus.ll_addr = 32'h7100;
    ex("scll_sc", SEL_SC, 1); tick();
    clr(); ex("scll_llbit", SEL_LLBIT, 0); ex("scll_lladdr", SEL_LLADDR, 32'h7000); tick();

    // 5: timeout after exactly 4 reserved cycles
    do_ll(32'h6000); tick();
    for (int i = 0; i < 4; i++) begin
      clr(); ex("t5_llbit_live", SEL_LLBIT, 1); ex("t5_lost_live", SEL_LOST, 0); tick();
    end
    clr(); ex("t5_llbit_timeout", SEL_LLBIT, 0); ex("t5_lost_pulse", SEL_LOST, 1); tick();
    clr(); ex("t5_lost_end", SEL_LOST, 0); tick();
    // 5b: re-issued LL in the third reserved cycle re-arms the timer
    do_ll(32'h6000); tick();
    for (int i = 0; i < 2; i++) begin
      clr(); ex("t5b_llbit_a", SEL_LLBIT, 1); tick();
    end
    do_ll(32'h6040); ex("t5b_llbit_rearm", SEL_LLBIT, 1); tick();
    for (int i = 0; i < 4; i++) begin
      clr(); ex("t5b_llbit_b", SEL_LLBIT, 1); ex("t5b_lost_b", SEL_LOST, 0); tick();
    end
    clr(); ex("t5b_llbit_timeout", SEL_LLBIT, 0); ex("t5b_lost_pulse", SEL_LOST, 1);
    ex("t5b_lladdr", SEL_LLADDR, 32'h6040); tick();

    // 6: reset in the middle of a reservation
    do_ll(32'h2000); tick();
    clr(); ex("t6_llbit", SEL_LLBIT, 1); ex("t6_lladdr", SEL_LLADDR, 32'h2000); tick();
    clr(); rst = 1'b1; tick();
    rst = 1'b0;
    do_sc(32'h2000); ex("t6_rst_llbit", SEL_LLBIT, 0); ex("t6_rst_lladdr", SEL_LLADDR, 0);
    ex("t6_rst_lost", SEL_LOST, 0); ex("t6_sc_fail", SEL_SC, 0); tick();
    clr(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/llsc_monitor.md
Name: llsc_monitor

Overview:
- Reservation controller for LL/SC atomics. Sequences the link bit and adds a link-address register, snoop-based invalidation and a reservation timeout, so the core can run in a multi-processor configuration.
- Sits beside the MEM stage:
  - takes ll/sc requests from the MEM stage;
  - takes exception flush from the exception controller;
  - takes store snoops from the interconnect;
  - returns the SC pass/fail result to MEM in the same cycle.

Parameters:
ADDR_W, 32, address width of ll/sc/snoop addresses.
GRAN_LSB, 2, low address bits ignored when comparing; 2 gives word granule, 4 gives a 16-byte line.
TIMEOUT, 1024, cycles a reservation may live before it is dropped; 0 disables the timeout.
CNT_W, 11, timeout counter width; must satisfy 2^CNT_W > TIMEOUT.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  reset, synchronous, active-high.
flush  in  1  exception/eret flush; clears the reservation.
ll_valid  in  1  LL executing in MEM this cycle.
ll_addr  in  ADDR_W  LL effective address.
sc_valid  in  1  SC executing in MEM this cycle.
sc_addr  in  ADDR_W  SC effective address.
snoop_valid  in  1  store from another agent observed this cycle.
snoop_addr  in  ADDR_W  address of the snooped store.
sc_success  out  1  combinational SC result; 1 means the store proceeds and rt is written with 1.
llbit_o  out  1  registered reservation valid; equals state==RESERVED.
lladdr_o  out  ADDR_W  registered link address.
resv_lost  out  1  registered one-cycle pulse when a live reservation is killed by snoop or timeout.

Behaviour:
- Reset: state=IDLE, llbit_o=0, lladdr_o=0, counter=0, resv_lost=0. Reset overrides every other input, mid-reservation included.
- Granule match: match(a,b) = (a[ADDR_W-1:GRAN_LSB] == b[ADDR_W-1:GRAN_LSB]).
- snoop_hit = snoop_valid & llbit_o & match(snoop_addr, lladdr_o).
- sc_success = sc_valid & llbit_o & match(sc_addr, lladdr_o) & ~snoop_hit & ~flush.
  - Pure combinational, zero latency.
  - 0 whenever sc_valid=0.
- FSM has two states, IDLE and RESERVED. Next-state priority, highest first:
  1. rst: go to IDLE, counter=0.
  2. flush: go to IDLE, counter=0, resv_lost=0. A flush is an architectural clear, not a loss.
  3. sc_valid: go to IDLE, counter=0, whether the SC passed or failed. Any ll_valid in the same cycle is ignored (illegal combination).
  4. ll_valid:
     - lladdr_o <= ll_addr and counter=0.
     - If snoop_valid & match(snoop_addr, ll_addr) in the same cycle, go to IDLE (conservative).
     - Otherwise go to RESERVED. This also re-arms from RESERVED with the new address.
  5. snoop_hit: go to IDLE, resv_lost=1.
  6. RESERVED & TIMEOUT!=0 & counter==TIMEOUT-1: go to IDLE, resv_lost=1.
  7. RESERVED otherwise: counter+1. In IDLE the counter holds at 0.
- Counter saturates; it never wraps.
- resv_lost is high for exactly one cycle after the kill edge, and 0 in all other cycles.
- lladdr_o changes only on an accepted LL (priority 4). It holds in IDLE, but the value has no meaning unless llbit_o=1.
- Snoops that miss, or arrive in IDLE, have no effect.
- With TIMEOUT=0, a reservation lives until sc, flush, snoop_hit or a new ll.

Test Plan:
1. LL 0x1000, then SC 0x1000 two cycles later.
   - sc_success=1 in the SC cycle.
   - llbit_o=0 the cycle after.
   - resv_lost stays 0.
2. LL 0x1000; snoop 0x1002 the next cycle (same word, GRAN_LSB=2).
   - llbit_o=0 and resv_lost=1 for one cycle.
   - A later SC 0x1000 gives sc_success=0.
3. LL 0x1000; SC 0x1004 → sc_success=0. A following SC 0x1000 → sc_success=0, because the reservation is already consumed.
4. LL, then SC and a matching snoop in the same cycle → sc_success=0, llbit_o=0. Repeat with flush=1 in the SC cycle → sc_success=0, resv_lost=0.
5. TIMEOUT=4: LL, then idle.
   - llbit_o=1 for exactly 4 cycles, then 0, with resv_lost pulsed.
   - Repeat with an LL re-issued in cycle 3: the reservation survives a further 4 cycles.
6. LL 0x2000, assert rst for one cycle mid-reservation → llbit_o=0, lladdr_o=0, resv_lost=0. A subsequent SC 0x2000 gives sc_success=0.
